// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one external pipelined multiplier among N requesters,
// with a credit-limited in-order result FIFO; results appear MUL_LAT+1 cycles after issue at best.
module mul_scheduler #(
    parameter int N       = 4,
    parameter int MUL_LAT = 3,
    parameter int DEPTH   = 4,
    localparam int IDW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_a,
    input  logic [8*N-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDW-1:0]   res_id,
    output logic [15:0]      res_data,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand;
    logic [N-1:0]     grant;
    logic             found;
    logic             credit_ok;
    logic             transfer;
    logic             push;
    logic             pop;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [MUL_LAT-1:0] tag_vld;
    logic [IDW-1:0]   tag_id [MUL_LAT];
    logic [IDW-1:0]   fifo_id [DEPTH];
    logic [15:0]      fifo_dat [DEPTH];

    // Every issued op owns a FIFO slot until popped, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last_grant) + k) % N);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        if (found && credit_ok && rst_n) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);
    assign mul_a     = transfer ? req_a[8*grant_id +: 8] : 8'd0;
    assign mul_b     = transfer ? req_b[8*grant_id +: 8] : 8'd0;

    assign push      = tag_vld[MUL_LAT-1];
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign res_id    = res_valid ? fifo_id[rd_ptr]  : '0;
    assign res_data  = res_valid ? fifo_dat[rd_ptr] : 16'd0;
    assign busy      = (inflight != '0) | res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(N - 1);
            tag_vld    <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            if (transfer) begin
                last_grant <= grant_id;
            end
            tag_vld[0] <= transfer;
            tag_id[0]  <= grant_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Storage needs no reset: entries are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= tag_id[MUL_LAT-1];
            fifo_dat[wr_ptr] <= mul_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({transfer, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler: round-robin/credit model plus in-order result scoreboard.
module tb_mul_scheduler;
    localparam int N       = 4;
    localparam int MUL_LAT = 3;
    localparam int DEPTH   = 4;
    localparam int IDW     = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_a;
    logic [8*N-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [15:0]      mul_p;
    logic             res_valid;
    logic             res_ready;
    logic [IDW-1:0]   res_id;
    logic [15:0]      res_data;
    logic             busy;

    logic [7:0]       av [N];
    logic [7:0]       bv [N];
    logic [15:0]      p_pipe [MUL_LAT];

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    p;
        int             t;
    } exp_t;

    exp_t           sb[$];
    logic [15:0]    popped_dat[$];
    logic [IDW-1:0] popped_id[$];
    logic [15:0]    corner_exp [N];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mlast = N - 1;
    int nxfer = 0;
    int t0    = 0;
    int last_pop_cyc = -1;
    logic [IDW-1:0] last_pop_id  = '0;
    logic [15:0]    last_pop_dat = '0;

    mul_scheduler #(.N(N), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] mulf(input logic signed [7:0] a, input logic signed [7:0] b);
        return a * b;
    endfunction

    // External multiplier with a fixed MUL_LAT-cycle pipeline
    always @(posedge clk) begin
        p_pipe[0] <= mulf(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mul_p = p_pipe[MUL_LAT-1];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = av[i];
            req_b[8*i +: 8] = bv[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_id"},    32'(res_id),    32'd0);
        check({tag, "_res_data"},  32'(res_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_mul_a"},     32'(mul_a),     32'd0);
        check({tag, "_mul_b"},     32'(mul_b),     32'd0);
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        logic         exp_vld;
        int           g;
        #2;
        exp_rdy = '0;
        g = -1;
        if (sb.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (mlast + k) % N;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("mul_a", 32'(mul_a), (g >= 0) ? 32'(av[g]) : 32'd0);
        check("mul_b", 32'(mul_b), (g >= 0) ? 32'(bv[g]) : 32'd0);
        exp_vld = (sb.size() > 0) && (cyc >= sb[0].t + MUL_LAT + 1);
        check("res_valid", 32'(res_valid), 32'(exp_vld));
        check("busy", 32'(busy), 32'(sb.size() > 0));
        if (exp_vld && res_valid) begin
            check("res_id",   32'(res_id),   32'(sb[0].id));
            check("res_data", 32'(res_data), 32'(sb[0].p));
        end
        if (exp_vld && res_ready) begin
            last_pop_cyc = cyc;
            last_pop_id  = res_id;
            last_pop_dat = res_data;
            popped_id.push_back(res_id);
            popped_dat.push_back(res_data);
            void'(sb.pop_front());
        end
        if (g >= 0) begin
            sb.push_back('{id: IDW'(g), p: mulf(av[g], bv[g]), t: cyc});
            mlast = g;
            nxfer++;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        corner_exp[0] = 16'h4000;
        corner_exp[1] = 16'hC080;
        corner_exp[2] = 16'h3F01;
        corner_exp[3] = 16'h0000;
        for (int i = 0; i < N; i++) begin
            av[i] = 8'h11;
            bv[i] = 8'h22;
        end
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (2) tick();

        // Single op from requester 2: -3 * 5
        av[2] = 8'hFD;
        bv[2] = 8'h05;
        res_ready = 1'b1;
        req_valid = 4'b0100;
        t0 = cyc;
        tick();
        req_valid = '0;
        repeat (6) tick();
        check("single_latency", 32'(last_pop_cyc), 32'(t0 + 4));
        check("single_id",      32'(last_pop_id),  32'd2);
        check("single_data",    32'(last_pop_dat), 32'h0000FFF1);

        // All requesters continuously valid, random operands
        req_valid = '1;
        repeat (16) begin
            for (int i = 0; i < N; i++) begin
                av[i] = 8'($urandom);
                bv[i] = 8'($urandom);
            end
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Consumer stalled: exactly DEPTH transfers; the single pop lands on a push at count DEPTH-1
        res_ready = 1'b0;
        req_valid = '1;
        nxfer = 0;
        repeat (6) tick();
        check("stall_transfers", 32'(nxfer), 32'(DEPTH));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        nxfer = 0;
        repeat (6) tick();
        check("one_more_transfer", 32'(nxfer), 32'd1);
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) tick();

        // Corner operands, one per requester
        av[0] = 8'h80; bv[0] = 8'h80;
        av[1] = 8'h80; bv[1] = 8'h7F;
        av[2] = 8'h7F; bv[2] = 8'h7F;
        av[3] = 8'h00; bv[3] = 8'hFF;
        popped_id.delete();
        popped_dat.delete();
        nxfer = 0;
        req_valid = '1;
        for (int i = 0; i < 20 && nxfer < 4; i++) tick();
        req_valid = '0;
        repeat (8) tick();
        check("corner_count", 32'(popped_dat.size()), 32'd4);
        foreach (popped_dat[i]) begin
            check("corner_data", 32'(popped_dat[i]), 32'(corner_exp[popped_id[i]]));
        end

        // Reset with three ops in flight
        req_valid = '1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_rst("midreset");
        sb.delete();
        mlast = N - 1;
        @(negedge clk);
        #1;
        chk_rst("midreset_hold");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (8) tick();
        av[0] = 8'h07; bv[0] = 8'hFE;
        req_valid = 4'b1001;
        tick();
        req_valid = '0;
        repeat (6) tick();
        check("post_reset_data", 32'(last_pop_dat), 32'h0000FFF2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning the shared multiplier's fixed latency in cycles (≥1).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the result FIFO entries, a power of 2 ≥2; IDW = clog2(N).
REQ-004 The block SHALL have port clk, in, 1, system clock.
REQ-005 The block SHALL have port rst_n, in, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port req_valid, in, N, per-requester operand valid.
REQ-007 The block SHALL have port req_a, in, 8*N, signed 8-bit A for requester i at [8i+7:8i].
REQ-008 The block SHALL have port req_b, in, 8*N, signed 8-bit B for requester i at [8i+7:8i].
REQ-009 The block SHALL have port req_ready, out, N, one-hot grant; a transfer occurs when req_valid[i]&req_ready[i].
REQ-010 The block SHALL have port mul_a, out, 8, operand A to the shared multiplier.
REQ-011 The block SHALL have port mul_b, out, 8, operand B to the shared multiplier.
REQ-012 The block SHALL have port mul_p, in, 16, signed product from the shared multiplier, valid MUL_LAT cycles after its operands.
REQ-013 The block SHALL have port res_valid, out, 1, FIFO head valid.
REQ-014 The block SHALL have port res_ready, in, 1, consumer accepts the head.
REQ-015 The block SHALL have port res_id, out, IDW, requester index of the head result.
REQ-016 The block SHALL have port res_data, out, 16, signed product of the head result.
REQ-017 The block SHALL have port busy, out, 1, high when any operation is in flight or the FIFO is non-empty.

Function
REQ-018 The block SHALL issue only when credit = inflight + fifo_count < DEPTH; a pop in the same cycle SHALL NOT enable the issue.
REQ-019 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps modulo N; at most one req_ready bit SHALL be high.
REQ-020 req_ready SHALL be combinational from req_valid, last_grant and the credit check, and SHALL be all-zero when the credit check fails.
REQ-021 last_grant SHALL update to the granted index only on a transfer cycle.
REQ-022 mul_a/mul_b SHALL be the granted requester's operands in the transfer cycle t, and 8'd0 when no transfer occurs.
REQ-023 A tag pipeline of MUL_LAT stages SHALL carry {valid, id}; the stage-0 valid SHALL be set only on a transfer.
REQ-024 When the tag leaves stage MUL_LAT-1 (cycle t+MUL_LAT), the block SHALL push {id, mul_p} into the FIFO.
REQ-025 res_valid SHALL rise in cycle t+MUL_LAT+1 if the FIFO was empty, giving a minimum issue-to-result latency of MUL_LAT+1 cycles.
REQ-026 The FIFO SHALL pop on res_valid&res_ready; simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-027 The credit rule SHALL guarantee the FIFO is never pushed while full; FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 inflight SHALL increment on a transfer, decrement on a push, and be unchanged when both occur in one cycle.
REQ-029 res_id/res_data SHALL be held stable while res_valid=1 and res_ready=0.
REQ-030 Results SHALL appear in issue order, regardless of requester.

Reset
REQ-031 While rst_n=0, the block SHALL clear all tag valids, FIFO pointers and count, and inflight.
REQ-032 While rst_n=0, last_grant SHALL be N-1 so that requester 0 has first priority.
REQ-033 While rst_n=0, outputs SHALL be: res_valid=0, res_id=0, res_data=0, busy=0, req_ready=0, mul_a=0, mul_b=0.
REQ-034 Reset mid-operation SHALL discard all in-flight and buffered results; no result SHALL emerge after reset release.

Verification
REQ-035 Single op: requester 2 sends A=-3, B=5 at cycle t with res_ready=1 -> res_valid in cycle t+4 with res_id=2, res_data=-15 (16'hFFF1).
REQ-036 All four requesters continuously valid -> grants 0,1,2,3,0,... with one transfer per cycle while credit allows.
REQ-037 res_ready=0 with continuous requests -> exactly DEPTH transfers, then req_ready=0; one pop -> exactly one further transfer.
REQ-038 Corner operands (-128×-128=16384, -128×127=-16256, 127×127=16129, 0×-1=0) -> exact signed results, in issue order.
REQ-039 Simultaneous push and pop at FIFO count=DEPTH-1 -> count unchanged, no loss or duplication.
REQ-040 rst_n asserted with 3 ops in flight -> all outputs at reset values immediately; after release, res_valid stays 0 until a new transfer.
